// File: rtl/uart_tx_fifo_drain_if.sv
// rtl/uart_tx_fifo_drain_if.sv - FIFO read-side handshake between the byte FIFO and the UART drain
interface uart_tx_fifo_drain_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en
   );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter that pops the byte FIFO and serialises each word
// Start, LSB-first data, optional parity and 1-2 stop bits; back-to-back frames pop on the final stop cycle.
module uart_tx_fifo_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_tx_fifo_drain_if.master fifo,
   input  logic                 tx_enable,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic [2:0] S_STOP   = 3'd5;

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     DATA_LAST = 4'(DATA_WIDTH - 1);
   localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

   logic [2:0]            state_q, state_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;

   logic bit_end;
   logic stop_last;
   logic pop;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign stop_last = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
   // rst_n gates the pop so a held reset never drains the FIFO.
   assign pop       = rst_n && tx_enable && !fifo.fifo_empty &&
                      ((state_q == S_IDLE) || stop_last);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      baud_d  = bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (pop) state_d = S_FETCH;
         end
         S_FETCH: begin
            baud_d  = '0;
            shift_d = fifo.fifo_dout;
            par_d   = (^fifo.fifo_dout) ^ (PARITY_ODD != 0);
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = pop ? S_FETCH : S_IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The line level is registered from the next state so it stays aligned with state_q.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   assign fifo.fifo_rd_en = pop;
   assign tx              = tx_q;
   assign busy            = (state_q != S_IDLE);
   assign tx_done         = stop_last;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - scoreboard bench for uart_tx_fifo_drain
module tb_uart_tx_fifo_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Default-configuration DUT fed by a bench FIFO model
   uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) f0();
   logic tx_en0, tx0, busy0, done0;

   uart_tx_fifo_drain dut0 (
      .clk(clk), .rst_n(rst_n), .fifo(f0),
      .tx_enable(tx_en0), .tx(tx0), .busy(busy0), .tx_done(done0)
   );

   // Parity / two-stop-bit DUTs sharing a one-word source
   logic p_empty;
   uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) f1();
   uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) f2();
   logic tx1, busy1, done1, tx2, busy2, done2;
   assign f1.fifo_empty = p_empty;
   assign f1.fifo_dout  = 8'h07;
   assign f2.fifo_empty = p_empty;
   assign f2.fifo_dout  = 8'h07;

   uart_tx_fifo_drain #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .fifo(f1),
      .tx_enable(1'b1), .tx(tx1), .busy(busy1), .tx_done(done1)
   );

   uart_tx_fifo_drain #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .fifo(f2),
      .tx_enable(1'b1), .tx(tx2), .busy(busy2), .tx_done(done2)
   );

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   int pushed = 0;
   int popped = 0;
   int npops0 = 0, npops1 = 0, npops2 = 0;
   logic mon_en;

   assign f0.fifo_empty = (pushed == popped);

   always @(posedge clk) begin
      if (f0.fifo_rd_en && fq.size() != 0) begin
         f0.fifo_dout <= fq.pop_front();
         popped       <= popped + 1;
      end
   end

   always @(negedge clk) begin
      if (f0.fifo_rd_en) begin
         npops0 = npops0 + 1;
         chk("pop_while_empty", int'(f0.fifo_empty), 0);
      end
      if (f1.fifo_rd_en) npops1 = npops1 + 1;
      if (f2.fifo_rd_en) npops2 = npops2 + 1;
   end

   // Bench UART receiver: samples mid-bit and scores each frame against the expected queue
   initial begin : monitor
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst_n && mon_en && tx0 == 1'b0) begin
            repeat (7) @(negedge clk);
            chk("rx_start", int'(tx0), 0);
            repeat (17) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = tx0;
               if (i < 7) repeat (16) @(negedge clk);
            end
            repeat (16) @(negedge clk);
            chk("rx_stop", int'(tx0), 1);
            if (exp_q.size() == 0) chk("rx_unexpected_frame", int'(b), -1);
            else                   chk("rx_byte", int'(b), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic push(input logic [7:0] b, input bit expect_it);
      fq.push_back(b);
      if (expect_it) exp_q.push_back(b);
      pushed++;
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_pop(output int t);
      t = -1;
      for (int i = 0; i < 3000; i++) begin
         if (f0.fifo_rd_en) begin
            t = cyc;
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL wait_pop: no fifo_rd_en within 3000 cycles");
   endtask

   task automatic wait_done(output int t);
      t = -1;
      for (int i = 0; i < 3000; i++) begin
         if (done0) begin
            t = cyc;
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL wait_done: no tx_done within 3000 cycles");
   endtask

   initial begin
      int t, c1, c2, np;
      rst_n   = 1'b1;
      tx_en0  = 1'b1;
      mon_en  = 1'b1;
      p_empty = 1'b1;
      #2 rst_n = 1'b0;

      // Reset held with data waiting and flow control open
      push(8'hA5, 1'b1);
      repeat (5) @(negedge clk);
      chk("reset_tx", int'(tx0), 1);
      chk("reset_rd_en", int'(f0.fifo_rd_en), 0);
      chk("reset_busy", int'(busy0), 0);
      chk("reset_done", int'(done0), 0);

      // Single 0xA5 frame timing
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("a5_pop", int'(f0.fifo_rd_en), 1);
      t = cyc;
      wait_cyc(t + 1);   chk("a5_fetch_tx", int'(tx0), 1);
                         chk("a5_fetch_busy", int'(busy0), 1);
      wait_cyc(t + 2);   chk("a5_start_first", int'(tx0), 0);
      wait_cyc(t + 17);  chk("a5_start_last", int'(tx0), 0);
      wait_cyc(t + 18);  chk("a5_bit0", int'(tx0), 1);
      wait_cyc(t + 34);  chk("a5_bit1", int'(tx0), 0);
      wait_cyc(t + 160); chk("a5_done_early", int'(done0), 0);
      wait_cyc(t + 161); chk("a5_done", int'(done0), 1);
                         chk("a5_stop_tx", int'(tx0), 1);
      wait_cyc(t + 162); chk("a5_busy_fall", int'(busy0), 0);
                         chk("a5_done_pulse", int'(done0), 0);

      // Back-to-back 0x00 then 0xFF
      np = npops0;
      push(8'h00, 1'b1);
      push(8'hFF, 1'b1);
      wait_pop(t);
      wait_done(c1);
      chk("b2b_pop_on_stop", int'(f0.fifo_rd_en), 1);
      wait_cyc(c1 + 1); chk("b2b_gap_tx", int'(tx0), 1);
                        chk("b2b_gap_busy", int'(busy0), 1);
      wait_cyc(c1 + 2); chk("b2b_second_start", int'(tx0), 0);
      wait_done(c2);
      chk("b2b_spacing", c2 - c1, 161);
      wait_cyc(c2 + 3);
      chk("b2b_pop_count", npops0 - np, 2);
      chk("b2b_idle", int'(busy0), 0);

      // Flow control
      tx_en0 = 1'b0;
      np = npops0;
      push(8'h3C, 1'b1);
      repeat (40) @(negedge clk);
      chk("fc_no_pop", npops0 - np, 0);
      chk("fc_tx_idle", int'(tx0), 1);
      tx_en0 = 1'b1;
      #1 chk("fc_pop_on_enable", int'(f0.fifo_rd_en), 1);
      t = cyc;
      wait_cyc(t + 50);
      tx_en0 = 1'b0;
      push(8'h81, 1'b1);
      wait_done(c1);
      chk("fc_no_pop_at_stop", int'(f0.fifo_rd_en), 0);
      repeat (30) @(negedge clk);
      chk("fc_one_pop", npops0 - np, 1);
      chk("fc_stays_idle", int'(busy0), 0);
      tx_en0 = 1'b1;
      #1;
      wait_pop(t);
      wait_done(c1);
      repeat (3) @(negedge clk);

      // Reset in the middle of the data bits
      mon_en = 1'b0;
      push(8'h00, 1'b0);
      wait_pop(t);
      wait_cyc(t + 60);
      chk("rst_mid_data_low", int'(tx0), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", int'(tx0), 1);
      chk("rst_mid_busy", int'(busy0), 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_mid_no_resend", int'(busy0), 0);

      // 256 random bytes through the scoreboard
      np = npops0;
      for (int i = 0; i < 256; i++) push(8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 50000 && !(pushed == popped && !busy0); i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("rand_pop_count", npops0 - np, 256);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_idle", int'(busy0), 0);

      // Empty source never popped, then parity / two-stop frames of 0x07
      chk("empty_no_pop1", npops1, 0);
      chk("empty_no_pop2", npops2, 0);
      chk("empty_tx1", int'(tx1), 1);
      p_empty = 1'b0;
      #1;
      chk("par_pop1", int'(f1.fifo_rd_en), 1);
      chk("par_pop2", int'(f2.fifo_rd_en), 1);
      t = cyc;
      @(negedge clk);
      p_empty = 1'b1;
      wait_cyc(t + 2);   chk("par_start", int'(tx1), 0);
      wait_cyc(t + 18);  chk("par_bit0", int'(tx1), 1);
      wait_cyc(t + 74);  chk("par_bit3", int'(tx1), 0);
      wait_cyc(t + 154); chk("par_even_bit", int'(tx1), 1);
                         chk("par_odd_bit", int'(tx2), 0);
      wait_cyc(t + 162); chk("par_stop1", int'(tx1), 1);
                         chk("par_done_early", int'(done1), 0);
      wait_cyc(t + 193); chk("par_done1", int'(done1), 1);
                         chk("par_done2", int'(done2), 1);
                         chk("par_stop2_tx", int'(tx2), 1);
      wait_cyc(t + 194); chk("par_busy1_fall", int'(busy1), 0);
                         chk("par_busy2_fall", int'(busy2), 0);
      repeat (5) @(negedge clk);
      chk("par_pops1", npops1, 1);
      chk("par_pops2", npops2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
